pit_irq_ctrl: RTL and testbench

PIT_IRQ_CTRL -- requirements
Module: pit_irq_ctrl

---
 rtl/pit_irq_ctrl.sv | 139 +++++++++++++
 tb/tb_pit_irq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pit_irq_ctrl.sv
// Interval-timer interrupt controller: latches per-channel pulses and presents them to the host round-robin.
// Overrun tracking is compiled in only when PIT_IRQ_OVERRUN_EN is defined.
module pit_irq_ctrl #(
  parameter int NUM_CH = 4,
  localparam int IDW = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq_pulse,
  input  logic [NUM_CH-1:0] irq_mask,
  input  logic              ack,
  input  logic              clear_overrun,
  output logic              irq,
  output logic [IDW-1:0]    irq_id,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun
);

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_e;

  state_e            state_q, state_d;
  logic              irq_q, irq_d;
  logic [IDW-1:0]    irq_id_q, irq_id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] ack_onehot;
  logic [IDW-1:0]    hi_pick, lo_pick, winner, id_inc;
  logic              hi_hit;

  // Round-robin: lowest eligible index at or above rr_ptr, else lowest eligible overall.
  always_comb begin
    eligible = pending_q & ~irq_mask;
    hi_pick  = '0;
    lo_pick  = '0;
    hi_hit   = 1'b0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (eligible[j]) begin
        lo_pick = IDW'(j);
        if (IDW'(j) >= rr_ptr_q) begin
          hi_pick = IDW'(j);
          hi_hit  = 1'b1;
        end
      end
    end
    winner = hi_hit ? hi_pick : lo_pick;
    id_inc = (irq_id_q == IDW'(NUM_CH - 1)) ? '0 : irq_id_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    irq_id_d   = irq_id_q;
    rr_ptr_d   = rr_ptr_q;
    ack_onehot = '0;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = ASSERT;
          irq_d    = 1'b1;
          irq_id_d = winner;
        end
      end
      ASSERT: begin
        if (ack) begin
          ack_onehot[irq_id_q] = 1'b1;
          rr_ptr_d = id_inc;
          irq_d    = 1'b0;
          state_d  = GAP;
        end
      end
      GAP: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A pulse landing on the acknowledged channel re-arms it as a fresh event.
  always_comb begin
    pending_d = (pending_q & ~ack_onehot) | irq_pulse;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
    end
  end

`ifdef PIT_IRQ_OVERRUN_EN
  logic [NUM_CH-1:0] overrun_q, overrun_d, ov_set;

  // Set has priority over clear so a loss in the clearing cycle is still reported.
  always_comb begin
    ov_set    = irq_pulse & pending_q & ~ack_onehot;
    overrun_d = (clear_overrun ? {NUM_CH{1'b0}} : overrun_q) | ov_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_clear_overrun;
  assign unused_clear_overrun = clear_overrun;
  assign overrun = '0;
`endif

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;

  a_irq_tracks_state: assert property (@(posedge clk) disable iff (reset)
    irq == (state_q == ASSERT));
  a_grant_stable: assert property (@(posedge clk) disable iff (reset)
    (state_q == ASSERT && !ack) |=> (irq && $stable(irq_id)));
  a_gap_quiet: assert property (@(posedge clk) disable iff (reset)
    (state_q == GAP) |-> !irq);

endmodule

// File: tb/tb_pit_irq_ctrl.sv
// Self-checking bench for pit_irq_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pit_irq_ctrl;
  localparam int N  = 4;
  localparam int IW = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_pulse, irq_mask;
  logic         ack, clear_overrun;
  logic         irq;
  logic [IW-1:0] irq_id;
  logic [N-1:0] pending, overrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0] m_pend, m_ov;
  bit           m_irq, m_gap;
  int           m_id, m_rr;

  always #5 clk = ~clk;

  pit_irq_ctrl #(.NUM_CH(N)) dut (
    .clk(clk), .reset(reset), .irq_pulse(irq_pulse), .irq_mask(irq_mask),
    .ack(ack), .clear_overrun(clear_overrun), .irq(irq), .irq_id(irq_id),
    .pending(pending), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: one call per clock edge, using the inputs that were stable before it.
  task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] mk,
                            input bit a, input bit cl, input bit rs);
    logic [N-1:0] nxt, ovs, elig;
    if (rs) begin
      m_pend = '0; m_ov = '0; m_irq = 0; m_gap = 0; m_id = 0; m_rr = 0;
      return;
    end
    nxt = m_pend | p;
    ovs = m_pend & p;
    if (m_irq) begin
      if (a) begin
        nxt[IW'(m_id)] = p[IW'(m_id)];
        ovs[IW'(m_id)] = 1'b0;
        m_rr  = (m_id + 1) % N;
        m_irq = 0;
        m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      elig = m_pend & ~mk;
      for (int k = 0; k < N; k++) begin
        if (elig[IW'((m_rr + k) % N)]) begin
          m_irq = 1;
          m_id  = (m_rr + k) % N;
          break;
        end
      end
    end
`ifdef PIT_IRQ_OVERRUN_EN
    m_ov = (cl ? '0 : m_ov) | ovs;
`else
    m_ov = '0;
`endif
    m_pend = nxt;
  endtask

  task automatic cyc(input logic [N-1:0] p, input logic [N-1:0] mk,
                     input bit a, input bit cl, input bit rs);
    irq_pulse = p; irq_mask = mk; ack = a; clear_overrun = cl; reset = rs;
    @(posedge clk);
    model_step(p, mk, a, cl, rs);
    #1;
    chk("irq", 32'(irq), 32'(m_irq));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("rr_ptr", 32'(dut.rr_ptr_q), 32'(m_rr));
    if (m_irq) chk("irq_id", 32'(irq_id), 32'(m_id));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 0, 0, 0);
  endtask

  logic [N-1:0] exp_ov2;
  logic [N-1:0] r_mask;

  initial begin
`ifdef PIT_IRQ_OVERRUN_EN
    exp_ov2 = 4'b0100;
`else
    exp_ov2 = 4'b0000;
`endif
    cyc('0, '0, 0, 0, 1);
    cyc(4'hF, '0, 1, 0, 1);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_ov", 32'(overrun), 0);

    // Single pulse on ch2, two-cycle latency, ack clears it
    idle(8);
    cyc(4'b0100, '0, 0, 0, 0);
    chk("s1_pend", 32'(pending), 32'h4);
    chk("s1_irq_early", 32'(irq), 0);
    idle(1);
    chk("s1_irq", 32'(irq), 1);
    chk("s1_id", 32'(irq_id), 2);
    idle(2);
    cyc('0, '0, 1, 0, 0);
    chk("s1_irq_off", 32'(irq), 0);
    chk("s1_pend_off", 32'(pending), 0);
    idle(2);

    // ch0 and ch3 together: ch0 first, gap, then ch3
    cyc('0, '0, 0, 0, 1);
    cyc(4'b1001, '0, 0, 0, 0);
    idle(1);
    chk("s2_first", 32'(irq_id), 0);
    cyc('0, '0, 1, 0, 0);
    chk("s2_gap", 32'(irq), 0);
    idle(2);
    chk("s2_second_irq", 32'(irq), 1);
    chk("s2_second", 32'(irq_id), 3);
    cyc('0, '0, 1, 0, 0);
    idle(2);

    // Masked ch1 latches but is not presented until unmasked
    cyc(4'b0010, 4'b0010, 0, 0, 0);
    cyc('0, 4'b0010, 0, 0, 0);
    cyc('0, 4'b0010, 0, 0, 0);
    chk("s3_pend", 32'(pending[1]), 1);
    chk("s3_masked", 32'(irq), 0);
    cyc('0, '0, 0, 0, 0);
    cyc('0, 4'b0010, 0, 0, 0);
    chk("s3_irq", 32'(irq), 1);
    chk("s3_id", 32'(irq_id), 1);
    cyc('0, '0, 1, 0, 0);
    idle(2);

    // Repeated ch2 pulse while pending, then clear, then set-beats-clear
    cyc('0, '0, 0, 0, 1);
    cyc(4'b0100, '0, 0, 0, 0);
    idle(2);
    cyc(4'b0100, '0, 0, 0, 0);
    chk("s4_ov", 32'(overrun), 32'(exp_ov2));
    cyc('0, '0, 0, 1, 0);
    chk("s4_clr", 32'(overrun), 0);
    cyc(4'b0100, '0, 0, 1, 0);
    chk("s4_setwins", 32'(overrun), 32'(exp_ov2));
    cyc('0, '0, 1, 1, 0);
    idle(2);

    // Pulse coincident with ack re-arms ch1 without overrun
    cyc('0, '0, 0, 0, 1);
    cyc(4'b0010, '0, 0, 0, 0);
    idle(1);
    cyc(4'b0010, '0, 1, 0, 0);
    chk("s5_pend", 32'(pending[1]), 1);
    chk("s5_ov", 32'(overrun[1]), 0);
    chk("s5_gap", 32'(irq), 0);
    idle(2);
    chk("s5_again", 32'(irq), 1);
    chk("s5_id", 32'(irq_id), 1);

    // Reset during ASSERT with 1011 pending and rr_ptr moved off zero
    cyc('0, '0, 0, 0, 1);
    cyc(4'b0100, '0, 0, 0, 0);
    idle(1);
    cyc('0, '0, 1, 0, 0);
    cyc(4'b1011, '0, 0, 0, 0);
    idle(1);
    chk("s6_pend", 32'(pending), 32'hB);
    chk("s6_id", 32'(irq_id), 3);
    cyc('0, '0, 0, 0, 1);
    chk("s6_irq", 32'(irq), 0);
    chk("s6_pend_rst", 32'(pending), 0);
    chk("s6_rr", 32'(dut.rr_ptr_q), 0);

    // Random traffic
    r_mask = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) r_mask = N'($urandom);
      cyc(($urandom_range(0, 3) == 0) ? N'($urandom) : '0, r_mask,
          $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
